sdram_rw_arbiter: RTL and testbench
===================================

// Module: sdram_rw_arbiter
// PURPOSE
//  Shares the single sdram_driver port between the camera write path and the VGA read path, one burst per grant.
//  Issues driver requests and generates burst addresses; owns frame ping-pong between two SDRAM banks (tear-free display).
//  Sits in the 100 MHz domain between the FIFO-level logic of the SDRAM control path and sdram_driver.
// PARAMETERS
//  BURST_LEN     512    words per driver burst (column span per request)
//  FRAME_BURSTS  1800   bursts per frame (1280*720/512)
//  IDX_W         11     width of burst index counters (>= clog2(FRAME_BURSTS))
// PORTS
//  clk           in   1   100 MHz system clock
//  rst_n         in   1   asynchronous active-low reset
//  wr_need       in   1   write FIFO holds >= BURST_LEN words
//  rd_need       in   1   read FIFO has room for >= BURST_LEN words
//  rd_urgent     in   1   read FIFO near empty; read wins regardless of round-robin
//  wr_sop        in   1   pulse: new camera frame starts (already synchronised to clk)
//  rd_sop        in   1   pulse: new display frame starts (already synchronised to clk)
//  drv_busy      in   1   sdram_driver busy (init/refresh/burst in progress)
//  drv_ack       in   1   sdram_driver one-cycle request acceptance
//  drv_wr_req    out  1   write request to driver
//  drv_rd_req    out  1   read request to driver
//  drv_addr      out  24  [23:22] bank, [21:9] row, [8:0] col
//  wr_grant      out  1   one-cycle pulse on write ack: write FIFO may start streaming
//  rd_grant      out  1   one-cycle pulse on read ack
//  frame_done    out  1   one-cycle pulse when a write frame completes
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; wr_buf=0; rd_buf=1; both burst indices 0; last_full=1; last_dir=RD.
//  FSM:
//   - IDLE -> REQ_WR / REQ_RD when drv_busy==0 and a need is present.
//   - REQ_x: hold drv_x_req=1 and a stable drv_addr until drv_ack; pulse x_grant on the ack cycle; -> WAIT.
//   - WAIT: stay while drv_busy==1, plus one cycle after the ack; -> IDLE when drv_busy==0.
//  Selection in IDLE: rd_urgent&rd_need -> RD; else both needs -> opposite of last_dir (round-robin); else the single need.
//  Address: drv_addr = {1'b0, buf, idx*BURST_LEN}, with idx*BURST_LEN zero-extended to 22 bits. Latched on entering REQ_x.
//  Write completion: on write ack, wr_idx++. When wr_idx reaches FRAME_BURSTS-1 and is acked:
//   - wr_idx -> 0, last_full <= wr_buf, wr_buf toggles, frame_done pulses.
//  Read frame: on rd_sop, rd_idx -> 0 and rd_buf <= last_full (the last completely written bank).
//   - On read ack rd_idx++, wrapping to 0 after FRAME_BURSTS-1 while rd_buf is kept.
//  wr_sop mid-frame (partial frame): wr_idx -> 0, no toggle, no frame_done.
//  Simultaneous events:
//   - sop and ack same cycle: sop wins (index -> 0); an in-flight request keeps its latched address.
//   - Frame-completing ack and rd_sop same cycle: rd_buf takes the NEW last_full.
//  Needs sampled only in IDLE; deasserting a need during REQ_x does not withdraw the request.
//  drv_wr_req and drv_rd_req are never high together; no request is issued while drv_busy==1 in IDLE.
//  Async reset mid-burst: outputs drop immediately and FSM returns to IDLE; the driver is reset by the same system reset.
//  Latency: need in IDLE with busy low -> request asserted next cycle.
// STRUCTURE
//  Shared package sdram_pkg: state encoding (IDLE, REQ_WR, REQ_RD, WAIT), bank/row/col field widths, BURST_LEN, FRAME_BURSTS.
//  One sub-module, sdram_frame_addr: burst index + buffer select + wrap/frame_done. Instantiated twice (wr, rd);
//   FSM and arbitration stay in the top.
// TESTING
//  1. Only wr_need=1, driver acks 2 cycles after req, busy 520 cycles
//     -> drv_addr 0x000000, 0x000200, 0x000400...; one wr_grant per burst.
//  2. wr_need=rd_need=1 steady -> grants alternate RD,WR,RD,WR... (first after reset is WR).
//  3. Both needs + rd_urgent=1 -> RD granted three times in a row; WR only after rd_urgent drops.
//  4. 1800 write acks -> frame_done pulse, next write addr 0x400000 (bank1);
//     rd_sop afterwards -> read addr 0x000000 (bank0).
//  5. wr_sop after 100 write bursts -> next write addr 0x000000 in the same bank; no frame_done.
//  6. Assert rst_n=0 while drv_wr_req=1 -> all outputs 0 asynchronously; after release, IDLE with addresses from 0.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM read/write arbiter.
// Contents: FSM state encoding, grant direction, address field widths,
// burst/frame sizing, and the burst-address helper.
package sdram_pkg;

    localparam int BURST_LEN    = 512;
    localparam int FRAME_BURSTS = 1800;
    localparam int IDX_W        = 11;

    localparam int BANK_W = 2;
    localparam int ROW_W  = 13;
    localparam int COL_W  = 9;
    localparam int ADDR_W = BANK_W + ROW_W + COL_W;
    localparam int OFS_W  = ADDR_W - BANK_W;
    localparam int BURST_SH = $clog2(BURST_LEN);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ_WR = 2'd1,
        ST_REQ_RD = 2'd2,
        ST_WAIT   = 2'd3
    } arb_state_e;

    typedef enum logic {
        DIR_WR = 1'b0,
        DIR_RD = 1'b1
    } dir_e;

    // Bank MSB is always 0: the two frame buffers live in banks 0 and 1.
    function automatic logic [ADDR_W-1:0] burst_addr(input logic             bank_sel,
                                                     input logic [IDX_W-1:0] idx);
        logic [OFS_W-1:0] ofs;
        ofs = OFS_W'(idx) << BURST_SH;
        return {1'b0, bank_sel, ofs};
    endfunction

endpackage

// File: rtl/sdram_rw_arbiter_if.sv
// Handshake bundle between the FIFO-level logic, the arbiter and sdram_driver.
// master: arbiter side (needs/driver status in, requests/address/grants out).
// slave : environment side (FIFO logic + driver model).
interface sdram_rw_arbiter_if;
    import sdram_pkg::*;

    logic              wr_need;
    logic              rd_need;
    logic              rd_urgent;
    logic              wr_sop;
    logic              rd_sop;
    logic              drv_busy;
    logic              drv_ack;
    logic              drv_wr_req;
    logic              drv_rd_req;
    logic [ADDR_W-1:0] drv_addr;
    logic              wr_grant;
    logic              rd_grant;
    logic              frame_done;

    modport master (
        input  wr_need, rd_need, rd_urgent, wr_sop, rd_sop, drv_busy, drv_ack,
        output drv_wr_req, drv_rd_req, drv_addr, wr_grant, rd_grant, frame_done
    );

    modport slave (
        output wr_need, rd_need, rd_urgent, wr_sop, rd_sop, drv_busy, drv_ack,
        input  drv_wr_req, drv_rd_req, drv_addr, wr_grant, rd_grant, frame_done
    );

endinterface

// File: rtl/sdram_frame_addr.sv
// Burst index and frame-buffer select for one stream (write or read).
// Ports:
//   clk, rst_n  clock / async active-low reset
//   ack_i       a burst of this stream was accepted by the driver
//   sop_i       start of frame: index restarts, select loads sop_sel_i
//   sop_sel_i   buffer select to adopt on sop_i
//   idx_o       current burst index within the frame
//   sel_o       current buffer (bank) select
module sdram_frame_addr
    import sdram_pkg::*;
#(
    parameter int N_BURSTS       = FRAME_BURSTS,
    parameter bit TOGGLE_ON_WRAP = 1'b0,
    parameter bit SEL_RST        = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ack_i,
    input  logic             sop_i,
    input  logic             sop_sel_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             sel_o
);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic             sel_q, sel_d;
    logic             last_w;

    assign last_w = (idx_q == IDX_W'(N_BURSTS - 1));

    // Start-of-frame overrides a same-cycle ack.
    always_comb begin
        idx_d = idx_q;
        sel_d = sel_q;
        if (sop_i) begin
            idx_d = '0;
            sel_d = sop_sel_i;
        end else if (ack_i) begin
            if (last_w) begin
                idx_d = '0;
                if (TOGGLE_ON_WRAP) begin
                    sel_d = ~sel_q;
                end
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            sel_q <= SEL_RST;
        end else begin
            idx_q <= idx_d;
            sel_q <= sel_d;
        end
    end

    assign idx_o = idx_q;
    assign sel_o = sel_q;

endmodule

// File: rtl/sdram_rw_arbiter.sv
// Shares the sdram_driver port between the camera write path and the VGA
// read path, one burst per grant, and ping-pongs frames between banks 0/1.
// Ports:
//   clk, rst_n  100 MHz clock / async active-low reset
//   bus         sdram_rw_arbiter_if.master (needs, sops, driver handshake,
//               requests, burst address, grants, frame_done)
//
// state     | meaning
// ----------+--------------------------------------------------
// ST_IDLE   | waiting for driver idle and a need; picks direction
// ST_REQ_WR | write request held with latched address until ack
// ST_REQ_RD | read request held with latched address until ack
// ST_WAIT   | burst in progress; leaves when driver drops busy
module sdram_rw_arbiter
    import sdram_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    sdram_rw_arbiter_if.master  bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BURSTS - 1);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    dir_e              last_dir_q, last_dir_d;
    logic              last_full_q, last_full_d;

    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic              wr_bank, rd_bank;
    logic              wr_ack, rd_ack;
    logic              wr_req, rd_req;
    logic              wr_done;
    logic              pick_rd;

    // A frame completes only if no new camera frame restarts it this cycle.
    assign wr_done     = wr_ack & (wr_idx == LAST_IDX) & ~bus.wr_sop;
    // Read side sees the freshly completed bank when both happen together.
    assign last_full_d = wr_done ? wr_bank : last_full_q;

    sdram_frame_addr #(
        .N_BURSTS       (FRAME_BURSTS),
        .TOGGLE_ON_WRAP (1'b1),
        .SEL_RST        (1'b0)
    ) u_wr_addr (
        .clk       (clk),
        .rst_n     (rst_n),
        .ack_i     (wr_ack),
        .sop_i     (bus.wr_sop),
        .sop_sel_i (wr_bank),
        .idx_o     (wr_idx),
        .sel_o     (wr_bank)
    );

    sdram_frame_addr #(
        .N_BURSTS       (FRAME_BURSTS),
        .TOGGLE_ON_WRAP (1'b0),
        .SEL_RST        (1'b1)
    ) u_rd_addr (
        .clk       (clk),
        .rst_n     (rst_n),
        .ack_i     (rd_ack),
        .sop_i     (bus.rd_sop),
        .sop_sel_i (last_full_d),
        .idx_o     (rd_idx),
        .sel_o     (rd_bank)
    );

    // Urgent read beats round-robin; with both needs, alternate from last_dir.
    assign pick_rd = bus.rd_need &
                     (bus.rd_urgent | ~bus.wr_need | (last_dir_q == DIR_WR));

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        last_dir_d = last_dir_q;
        wr_req     = 1'b0;
        rd_req     = 1'b0;
        wr_ack     = 1'b0;
        rd_ack     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!bus.drv_busy) begin
                    if (pick_rd) begin
                        state_d = ST_REQ_RD;
                        addr_d  = burst_addr(rd_bank, rd_idx);
                    end else if (bus.wr_need) begin
                        state_d = ST_REQ_WR;
                        addr_d  = burst_addr(wr_bank, wr_idx);
                    end
                end
            end
            ST_REQ_WR: begin
                wr_req = 1'b1;
                if (bus.drv_ack) begin
                    wr_ack     = 1'b1;
                    last_dir_d = DIR_WR;
                    state_d    = ST_WAIT;
                end
            end
            ST_REQ_RD: begin
                rd_req = 1'b1;
                if (bus.drv_ack) begin
                    rd_ack     = 1'b1;
                    last_dir_d = DIR_RD;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!bus.drv_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            last_dir_q  <= DIR_RD;
            last_full_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_dir_q  <= last_dir_d;
            last_full_q <= last_full_d;
        end
    end

    assign bus.drv_wr_req = wr_req;
    assign bus.drv_rd_req = rd_req;
    assign bus.drv_addr   = addr_q;
    assign bus.wr_grant   = wr_ack;
    assign bus.rd_grant   = rd_ack;
    assign bus.frame_done = wr_done;

endmodule

// File: tb/tb_sdram_rw_arbiter.sv
module tb_sdram_rw_arbiter;
    import sdram_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sdram_rw_arbiter_if bus ();

    sdram_rw_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit          rst;
        bit          wr;
        bit          rd;
        bit          urg;
        bit          exp_wr;
        logic [23:0] addr;
        int          busy;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.wr_need   = 1'b0;
        bus.rd_need   = 1'b0;
        bus.rd_urgent = 1'b0;
        bus.wr_sop    = 1'b0;
        bus.rd_sop    = 1'b0;
        bus.drv_busy  = 1'b0;
        bus.drv_ack   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called at a negedge. Waits for a request, checks direction/address,
    // acks after ack_dly cycles, then holds busy for busy_cyc cycles.
    task automatic burst(input bit exp_wr, input logic [23:0] exp_addr,
                         input int ack_dly, input int busy_cyc,
                         input bit sop_w, input bit sop_r, input bit exp_done,
                         input string tag);
        int          n;
        logic [23:0] a0;
        bit          stable;
        n = 0;
        while (!(bus.drv_wr_req || bus.drv_rd_req) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " req_seen"}, 32'(bus.drv_wr_req | bus.drv_rd_req), 32'd1);
        if (!(bus.drv_wr_req || bus.drv_rd_req)) return;
        chk({tag, " wr_req"}, 32'(bus.drv_wr_req), 32'(exp_wr));
        chk({tag, " rd_req"}, 32'(bus.drv_rd_req), 32'(!exp_wr));
        chk({tag, " addr"}, 32'(bus.drv_addr), 32'(exp_addr));
        a0     = bus.drv_addr;
        stable = 1'b1;
        repeat (ack_dly) begin
            @(negedge clk);
            if (bus.drv_addr !== a0 || !(exp_wr ? bus.drv_wr_req : bus.drv_rd_req))
                stable = 1'b0;
        end
        bus.drv_ack  = 1'b1;
        bus.drv_busy = 1'b1;
        bus.wr_sop   = sop_w;
        bus.rd_sop   = sop_r;
        #1;
        chk({tag, " req_held"}, 32'(stable), 32'd1);
        chk({tag, " wr_grant"}, 32'(bus.wr_grant), 32'(exp_wr));
        chk({tag, " rd_grant"}, 32'(bus.rd_grant), 32'(!exp_wr));
        chk({tag, " frame_done"}, 32'(bus.frame_done), 32'(exp_done));
        @(negedge clk);
        bus.drv_ack = 1'b0;
        bus.wr_sop  = 1'b0;
        bus.rd_sop  = 1'b0;
        #1;
        chk({tag, " grant_pulse"}, 32'(bus.wr_grant | bus.rd_grant | bus.frame_done), 32'd0);
        chk({tag, " req_drop"}, 32'(bus.drv_wr_req | bus.drv_rd_req), 32'd0);
        @(negedge clk);
        repeat (busy_cyc - 1) @(negedge clk);
        bus.drv_busy = 1'b0;
    endtask

    initial begin
        vec_t vecs[13];
        int   n;
        vecs[0]  = '{0, 1, 0, 0, 1, 24'h000000, 520};
        vecs[1]  = '{0, 1, 0, 0, 1, 24'h000200, 520};
        vecs[2]  = '{0, 1, 0, 0, 1, 24'h000400, 520};
        vecs[3]  = '{1, 1, 1, 0, 1, 24'h000000, 3};
        vecs[4]  = '{0, 1, 1, 0, 0, 24'h400000, 3};
        vecs[5]  = '{0, 1, 1, 0, 1, 24'h000200, 3};
        vecs[6]  = '{0, 1, 1, 0, 0, 24'h400200, 3};
        vecs[7]  = '{0, 1, 1, 1, 0, 24'h400400, 3};
        vecs[8]  = '{0, 1, 1, 1, 0, 24'h400600, 3};
        vecs[9]  = '{0, 1, 1, 1, 0, 24'h400800, 3};
        vecs[10] = '{0, 1, 1, 0, 1, 24'h000400, 3};
        vecs[11] = '{0, 0, 1, 0, 0, 24'h400A00, 3};
        vecs[12] = '{0, 1, 0, 1, 1, 24'h000600, 3};

        do_reset();
        #1;
        chk("rst wr_req", 32'(bus.drv_wr_req), 32'd0);
        chk("rst rd_req", 32'(bus.drv_rd_req), 32'd0);
        chk("rst addr", 32'(bus.drv_addr), 32'd0);
        chk("rst grants", 32'(bus.wr_grant | bus.rd_grant), 32'd0);
        chk("rst frame_done", 32'(bus.frame_done), 32'd0);
        @(negedge clk);

        // Arbitration table: write-only, round-robin, urgent read.
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].rst) do_reset();
            bus.wr_need   = vecs[i].wr;
            bus.rd_need   = vecs[i].rd;
            bus.rd_urgent = vecs[i].urg;
            burst(vecs[i].exp_wr, vecs[i].addr, 2, vecs[i].busy, 0, 0, 0,
                  $sformatf("vec%0d", i));
        end
        bus.wr_need   = 1'b0;
        bus.rd_need   = 1'b0;
        bus.rd_urgent = 1'b0;

        // No request while busy in IDLE; request one cycle after busy drops.
        do_reset();
        bus.drv_busy = 1'b1;
        bus.wr_need  = 1'b1;
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.drv_wr_req || bus.drv_rd_req) n++;
        end
        chk("busy_blocks_req", 32'(n), 32'd0);
        bus.drv_busy = 1'b0;
        @(negedge clk);
        chk("req_latency", 32'(bus.drv_wr_req), 32'd1);
        // Need withdrawn during REQ does not cancel the request.
        bus.wr_need = 1'b0;
        burst(1, 24'h000000, 2, 2, 0, 0, 0, "withdraw");

        // Full write frame; completing ack coincides with rd_sop.
        do_reset();
        bus.wr_need = 1'b1;
        for (int i = 0; i < FRAME_BURSTS; i++) begin
            burst(1, 24'(i * 512), 1, 1, 0, (i == FRAME_BURSTS - 1),
                  (i == FRAME_BURSTS - 1), $sformatf("frm%0d", i));
        end
        burst(1, 24'h400000, 1, 1, 0, 0, 0, "bank1_first");
        bus.wr_need = 1'b0;
        bus.rd_need = 1'b1;
        burst(0, 24'h000000, 1, 1, 0, 0, 0, "rd_last_full");
        bus.rd_need = 1'b0;

        // Partial frame restart, then sop coinciding with an ack.
        do_reset();
        bus.wr_need = 1'b1;
        for (int i = 0; i < 100; i++) begin
            burst(1, 24'(i * 512), 1, 1, 0, 0, 0, $sformatf("part%0d", i));
        end
        bus.wr_need = 1'b0;
        repeat (3) @(negedge clk);
        bus.wr_sop = 1'b1;
        @(negedge clk);
        bus.wr_sop = 1'b0;
        #1;
        chk("sop no frame_done", 32'(bus.frame_done), 32'd0);
        @(negedge clk);
        bus.wr_need = 1'b1;
        burst(1, 24'h000000, 1, 1, 0, 0, 0, "after_sop");
        burst(1, 24'h000200, 1, 1, 1, 0, 0, "sop_with_ack");
        burst(1, 24'h000000, 1, 1, 0, 0, 0, "sop_won");

        // Async reset while a write request is pending.
        n = 0;
        while (!bus.drv_wr_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("pre_rst addr", 32'(bus.drv_addr), 32'h000200);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async wr_req", 32'(bus.drv_wr_req), 32'd0);
        chk("async addr", 32'(bus.drv_addr), 32'd0);
        chk("async grants", 32'(bus.wr_grant | bus.rd_grant | bus.frame_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        burst(1, 24'h000000, 1, 1, 0, 0, 0, "post_rst");
        bus.wr_need = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
